// File: rtl/counter_sweep_arbiter_if.sv
// Job request, completion and counter-control signals shared between the
// sweep arbiter and its environment.
interface counter_sweep_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_start0;
    logic [WIDTH-1:0] req_end0;
    logic [WIDTH-1:0] req_start1;
    logic [WIDTH-1:0] req_end1;
    logic [1:0]       done;
    logic [1:0]       err;
    logic             busy;
    logic             owner;
    logic             ctr_load;
    logic             ctr_up_down;
    logic [WIDTH-1:0] ctr_data;
    logic [WIDTH-1:0] ctr_count;

    modport slave (
        input  req_valid, req_start0, req_end0, req_start1, req_end1, ctr_count,
        output req_ready, done, err, busy, owner, ctr_load, ctr_up_down, ctr_data
    );

    modport master (
        output req_valid, req_start0, req_end0, req_start1, req_end1, ctr_count,
        input  req_ready, done, err, busy, owner, ctr_load, ctr_up_down, ctr_data
    );
endinterface

// File: rtl/counter_sweep_arbiter.sv
// Shares one loadable up/down counter between two sweep requesters.
// Round-robin grant, one LOAD cycle, then RUN until the count hits the
// job's end value (done) or the watchdog expires (err).
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for a request, counter free-runs
// LOAD  | ctr_load asserted with the captured start value
// RUN   | comparing ctr_count against end, watchdog running
module counter_sweep_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    counter_sweep_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    // Timeout fires at RUN index 2^WIDTH without a match.
    localparam logic [WIDTH:0] RUN_LIMIT = {1'b1, {WIDTH{1'b0}}};

    state_t           state;
    logic             last_served;
    logic             owner_q;
    logic [1:0]       done_q;
    logic [1:0]       err_q;
    logic             load_q;
    logic             up_down_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] end_q;
    logic [WIDTH:0]   run_idx;

    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] sel_start;
    logic [WIDTH-1:0] sel_end;

    // Round-robin pick: contention goes to the requester not served last.
    always_comb begin
        grant = 1'b0;
        if (bus.req_valid == 2'b11) begin
            grant = ~last_served;
        end else if (bus.req_valid[1]) begin
            grant = 1'b1;
        end
    end

    assign sel_start = grant ? bus.req_start1 : bus.req_start0;
    assign sel_end   = grant ? bus.req_end1   : bus.req_end0;

    assign bus.req_ready = (state == IDLE && !rst && (|bus.req_valid))
                           ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign accept        = |bus.req_ready;

    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.busy        = (state != IDLE);
    assign bus.owner       = owner_q;
    assign bus.ctr_load    = load_q;
    assign bus.ctr_up_down = up_down_q;
    assign bus.ctr_data    = data_q;

    // Sequencer: capture job, load counter, watch for end value or timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            owner_q     <= 1'b0;
            done_q      <= 2'b00;
            err_q       <= 2'b00;
            load_q      <= 1'b0;
            up_down_q   <= 1'b1;
            data_q      <= '0;
            end_q       <= '0;
            run_idx     <= '0;
        end else begin
            done_q <= 2'b00;
            err_q  <= 2'b00;
            load_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q      <= sel_start;
                        end_q       <= sel_end;
                        owner_q     <= grant;
                        last_served <= grant;
                        up_down_q   <= (sel_end >= sel_start);
                        load_q      <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    run_idx <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    if (bus.ctr_count == end_q) begin
                        done_q[owner_q] <= 1'b1;
                        state           <= IDLE;
                    end else if (run_idx == RUN_LIMIT) begin
                        err_q[owner_q] <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        run_idx <= run_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/counter_sweep_arbiter.md
# counter_sweep_arbiter

Controller that shares one loadable up/down synchronous counter (load/data/up_down/count interface) between two requesters. Each requester submits a sweep job (start value, end value) over a valid/ready handshake. The block arbitrates round-robin, loads the counter with the start value and selects the count direction. It watches the count until it reaches the end value, then pulses done to the job owner. A watchdog flags a counter that never reaches the end value.

## Interface
Parameters:
- WIDTH, 4, width of counter value, start/end fields and ctr_data/ctr_count

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  job request per requester (bit i = requester i)
- req_ready  out  2  job accept per requester; combinational
- req_start0, req_end0  in  WIDTH each  requester 0 job fields
- req_start1, req_end1  in  WIDTH each  requester 1 job fields
- done  out  2  one-cycle completion pulse to owner
- err  out  2  one-cycle watchdog pulse to owner
- busy  out  1  high while a job is in LOAD or RUN
- owner  out  1  index of current or most recent job owner
- ctr_load  out  1  to counter load
- ctr_up_down  out  1  to counter up_down (1 = up)
- ctr_data  out  WIDTH  to counter data
- ctr_count  in  WIDTH  from counter count

## Operation
- States: IDLE, LOAD, RUN.
- IDLE:
  - The grant goes to the requester with valid set. If both are valid, it goes to the requester not served last; last_served resets to 1, so requester 0 wins first.
  - req_ready[g] = 1 for the granted requester only, and only in IDLE with rst low. Every other ready bit is 0.
  - On valid&ready: capture start and end, owner <= g, last_served <= g, dir <= (end >= start). Next state is LOAD.
- LOAD (one cycle): ctr_load = 1, ctr_data = start, ctr_up_down = dir. Next state is RUN.
- RUN:
  - ctr_load = 0 and ctr_up_down = dir.
  - Each cycle, compare ctr_count with end.
  - On a match: done[owner] pulses the next cycle and the state returns to IDLE.
- Watchdog:
  - A RUN cycle index counts from 0 at the first RUN cycle. It is WIDTH+1 bits wide.
  - If no match occurs in 2^WIDTH consecutive RUN cycles, err[owner] pulses the next cycle and the state returns to IDLE.
  - done is not asserted for that job.
- Direction never produces wrap-around in a correct sweep: end < start selects down, end >= start selects up. The counter's wrap is therefore only reachable under a fault.
- start == end is legal. It matches on the first RUN cycle.
- ctr_data holds the last captured start. ctr_up_down holds the last dir.
- While in IDLE the counter free-runs; its value is ignored.
- busy = (state != IDLE).

## Timing
- Accept handshake in cycle T: LOAD in T+1.
  - ctr_count == start in T+2, which is RUN index 0.
  - Match in T+2+|end-start|.
  - done and IDLE in T+3+|end-start|.
- A new job may be accepted in the same cycle done pulses.
- done and err are registered one-cycle pulses. They are never both high, and never for both bits.
- Watchdog err appears in T+3+2^WIDTH.
- Reset values:
  - state = IDLE, req_ready = 0, done = 0, err = 0, busy = 0, owner = 0.
  - ctr_load = 0, ctr_up_down = 1, ctr_data = 0, last_served = 1.
- rst asserted mid-LOAD or mid-RUN: the job is abandoned and no done or err is issued. All registers return to their reset values on the next edge.
- A requester that deasserts valid before ready is not served. Job fields are sampled only in the accept cycle.

## Test plan
- Up sweep: with the reference counter attached, req0 issues start=3, end=7 and is accepted at T. Expect ctr_load=1 with data=3 at T+1, counts 3..7 over T+2..T+6, done=2'b01 at T+7, busy low at T+7.
- Down sweep: req1 issues start=9, end=2. Expect ctr_up_down=0, counts 9..2, done=2'b10 at T+10, owner=1.
- Degenerate job: req0 issues start=end=5. Expect done[0] at T+3.
- Arbitration: both valid from reset with 2-step jobs, held continuously.
  - Grants alternate 0,1,0,1.
  - The ready bits are never both high.
  - Each new accept coincides with the previous done.
- Watchdog: the bench holds ctr_count at 0 for job start=4, end=12 from req1. Expect no done, err=2'b10 at T+19 (WIDTH=4), then IDLE.
- Reset mid-run: rst pulses during RUN of a 3→14 job. Expect all outputs at reset values next cycle, no done or err, and the next request with both valid granted to req0.
